regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (DstReg/WriteReg/DstData) between two writeback
//  requesters: A = ALU, B = memory load. Each requester has a small FIFO with a valid/ready handshake.
//  A round-robin arbiter drains one entry per cycle into a registered write port.
//  A pending-write mask tells decode which registers still have queued writes, so decode can stall on RAW.
// PARAMETERS
//  DEPTH   2   entries per requester FIFO (1..8)
//  DATA_W  16  writeback data width; must match the register file
// PORTS
//  clk       in   1       clock; all state updates on the rising edge
//  rst       in   1       asynchronous reset, active-low (0 = reset)
//  flush     in   1       synchronous clear of both queues and the write port
//  a_valid   in   1       requester A has a write
//  a_ready   out  1       requester A FIFO can accept
//  a_reg     in   4       requester A destination register
//  a_data    in   DATA_W  requester A write data
//  b_valid   in   1       requester B has a write
//  b_ready   out  1       requester B FIFO can accept
//  b_reg     in   4       requester B destination register
//  b_data    in   DATA_W  requester B write data
//  DstReg    out  4       to register file DstReg
//  WriteReg  out  1       to register file WriteReg
//  DstData   out  DATA_W  to register file DstData
//  pend_mask out  16      bit r = 1: a write to register r is queued or on the port
// BEHAVIOUR
//  - Reset (rst=0, async): both FIFO counts and pointers = 0; WriteReg = 0; DstReg = 0; DstData = 0;
//    last_grant = B, so A wins the first contention; pend_mask = 0.
//  - Ready:
//    - x_ready = (count_x < DEPTH) && !flush. It depends only on state, never on x_valid.
//    - There is no pass-through when full: a full FIFO stays not-ready even in a cycle where it is popped.
//  - Push: x_valid && x_ready at an edge writes {reg,data} at the tail.
//  - Arbiter FSM, states IDLE / GRANT_A / GRANT_B, evaluated every cycle:
//    - Both FIFOs empty -> IDLE.
//    - Exactly one FIFO non-empty -> grant it.
//    - Both non-empty -> grant the one != last_grant.
//    - On a grant: pop the head; WriteReg <= 1; DstReg/DstData <= head; last_grant <= granted side.
//    - With no grant, WriteReg <= 0. DstReg and DstData hold their last values.
//  - Latency: push accepted at edge t -> WriteReg high during t+1..t+2 -> register file commits at edge t+2.
//  - Throughput: 1 write per cycle overall. Under continuous contention A and B strictly alternate.
//  - Ordering:
//    - FIFO order is kept within each requester.
//    - No ordering is guaranteed between A and B. Decode must use pend_mask to avoid a cross-requester WAW.
//  - Simultaneous push and pop on the same FIFO: count stays unchanged; pointers wrap modulo DEPTH.
//  - pend_mask = OR of one-hot(reg) over all valid FIFO entries, OR one-hot(DstReg) when WriteReg=1.
//    - A register's bit clears the cycle after its last write is presented to the register file.
//  - flush = 1 at an edge:
//    - counts and pointers <= 0; WriteReg <= 0; last_grant is unchanged.
//    - Pushes that cycle are dropped, because ready is low.
//    - A write already on the port during the flush cycle still commits.
//  - rst asserted mid-operation: all queued writes are lost and WriteReg drops immediately (async).
// CONFIGURATION
//  WB_R0_DROP_EN
//  - Defined:
//    - A push with reg == 0 completes its handshake (ready as normal) but is not enqueued.
//    - It never reaches the write port and never sets pend_mask[0]; R0 behaves as constant.
//  - Undefined: R0 is written like any other register.
// TESTING
//  - Single A push {reg=3, data=16'hBEEF} -> WriteReg=1, DstReg=3, DstData=BEEF one cycle later;
//    pend_mask[3] high for 2 cycles.
//  - A and B both valid every cycle with DEPTH=2 -> port output is A0,B0,A1,B1,...; no entry lost;
//    each a_ready/b_ready never low >1 cycle.
//  - Fill A with 2 entries while B pushes continuously -> a_ready=0 at count 2; A entries still
//    drain interleaved with B.
//  - Queue A {reg=5}, B {reg=5}, flush on the next edge -> no WriteReg pulse after the flush edge;
//    pend_mask=0 the following cycle.
//  - Drop rst low mid-burst with 3 entries queued -> WriteReg=0, pend_mask=0 immediately; first write
//    after release is a new push.
//  - WB_R0_DROP_EN defined, A pushes {reg=0, data=16'h1234} -> a_ready=1 at accept, WriteReg stays 0,
//    pend_mask[0]=0; undefined -> write of 1234 to R0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter in front of the register file's single write port.
// Optional feature macro WB_R0_DROP_EN: accepted pushes to R0 are discarded so R0 stays constant.
module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [3:0]        a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [3:0]        b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic [3:0]        DstReg,
  output logic              WriteReg,
  output logic [DATA_W-1:0] DstData,
  output logic [15:0]       pend_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_W + 4;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_A = 2'd1, GRANT_B = 2'd2} state_t;

  // Index 0 is requester A (ALU), index 1 is requester B (load).
  logic [1:0]       in_valid_s, ready_s, push_s, enq_s, pop_s;
  logic [ENT_W-1:0] in_ent_s [2];
  logic [ENT_W-1:0] mem_q [2][DEPTH];
  logic [ENT_W-1:0] mem_d [2][DEPTH];
  logic [DEPTH-1:0] vld_q [2];
  logic [DEPTH-1:0] vld_d [2];
  logic [PTR_W-1:0] wptr_q [2];
  logic [PTR_W-1:0] wptr_d [2];
  logic [PTR_W-1:0] rptr_q [2];
  logic [PTR_W-1:0] rptr_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [3:0]       dst_reg_q, dst_reg_d;
  logic [DATA_W-1:0] dst_data_q, dst_data_d;
  logic [15:0]      pend_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Handshake: ready depends only on occupancy and flush, never on valid.
  always_comb begin
    in_valid_s  = {b_valid, a_valid};
    in_ent_s[0] = {a_reg, a_data};
    in_ent_s[1] = {b_reg, b_data};
    for (int s = 0; s < 2; s++) begin
      ready_s[s] = (cnt_q[s] < CNT_FULL) && !flush;
      push_s[s]  = in_valid_s[s] && ready_s[s];
    end
`ifdef WB_R0_DROP_EN
    enq_s = {push_s[1] && (b_reg != 4'd0), push_s[0] && (a_reg != 4'd0)};
`else
    enq_s = push_s;
`endif
  end

  // Arbiter next state: alternate under contention, else serve whichever side has data.
  always_comb begin
    if (flush) begin
      state_d = IDLE;
    end else if ((cnt_q[0] != {CNT_W{1'b0}}) && (cnt_q[1] != {CNT_W{1'b0}})) begin
      state_d = last_q ? GRANT_A : GRANT_B;
    end else if (cnt_q[0] != {CNT_W{1'b0}}) begin
      state_d = GRANT_A;
    end else if (cnt_q[1] != {CNT_W{1'b0}}) begin
      state_d = GRANT_B;
    end else begin
      state_d = IDLE;
    end
  end

  // Arbiter outputs: pop the granted head and load it into the write port.
  always_comb begin
    pop_s      = 2'b00;
    last_d     = last_q;
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    case (state_d)
      GRANT_A: begin
        pop_s                   = 2'b01;
        last_d                  = 1'b0;
        {dst_reg_d, dst_data_d} = mem_q[0][rptr_q[0]];
      end
      GRANT_B: begin
        pop_s                   = 2'b10;
        last_d                  = 1'b1;
        {dst_reg_d, dst_data_d} = mem_q[1][rptr_q[1]];
      end
      default: begin
        pop_s = 2'b00;
      end
    endcase
  end

  // FIFO bookkeeping for both requesters.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wptr_d[s] = wptr_q[s];
      rptr_d[s] = rptr_q[s];
      cnt_d[s]  = cnt_q[s];
      vld_d[s]  = vld_q[s];
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[s][i] = mem_q[s][i];
      end
      if (flush) begin
        wptr_d[s] = {PTR_W{1'b0}};
        rptr_d[s] = {PTR_W{1'b0}};
        cnt_d[s]  = {CNT_W{1'b0}};
        vld_d[s]  = {DEPTH{1'b0}};
      end else begin
        if (pop_s[s]) begin
          vld_d[s][rptr_q[s]] = 1'b0;
          rptr_d[s]           = ptr_inc(rptr_q[s]);
        end else begin
          rptr_d[s] = rptr_q[s];
        end
        if (enq_s[s]) begin
          mem_d[s][wptr_q[s]] = in_ent_s[s];
          vld_d[s][wptr_q[s]] = 1'b1;
          wptr_d[s]           = ptr_inc(wptr_q[s]);
        end else begin
          wptr_d[s] = wptr_q[s];
        end
        case ({enq_s[s], pop_s[s]})
          2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
          2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
          default: cnt_d[s] = cnt_q[s];
        endcase
      end
    end
  end

  // Pending-write mask: every valid queued entry plus the write currently on the port.
  always_comb begin
    pend_s = 16'h0000;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        pend_s = pend_s | (vld_q[s][i] ? (16'h0001 << mem_q[s][i][ENT_W-1 -: 4]) : 16'h0000);
      end
    end
    pend_s = pend_s | ((state_q != IDLE) ? (16'h0001 << dst_reg_q) : 16'h0000);
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= {PTR_W{1'b0}};
        rptr_q[s] <= {PTR_W{1'b0}};
        cnt_q[s]  <= {CNT_W{1'b0}};
        vld_q[s]  <= {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[s][i] <= {ENT_W{1'b0}};
        end
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
        cnt_q[s]  <= cnt_d[s];
        vld_q[s]  <= vld_d[s];
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[s][i] <= mem_d[s][i];
        end
      end
    end
  end

  // Arbiter state and registered write port; last grant resets to B so A wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      dst_reg_q  <= 4'd0;
      dst_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
    end
  end

  assign a_ready   = ready_s[0];
  assign b_ready   = ready_s[1];
  assign WriteReg  = (state_q != IDLE);
  assign DstReg    = dst_reg_q;
  assign DstData   = dst_data_q;
  assign pend_mask = pend_s;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: accepted pushes are queued per requester and
// every port write must match the head of one of those queues.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [3:0]  a_reg = 4'd0, b_reg = 4'd0;
  logic [15:0] a_data = 16'h0000, b_data = 16'h0000;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] pend_mask;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_a[$];
  logic [19:0] exp_b[$];
  int          obs[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(2), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData), .pend_mask(pend_mask)
  );

  // Record accepted pushes; a flush discards everything still queued.
  always @(posedge clk) begin
    if (rst && flush) begin
      exp_a.delete();
      exp_b.delete();
    end else if (rst) begin
`ifdef WB_R0_DROP_EN
      if (a_valid && a_ready && a_reg != 4'd0) exp_a.push_back({a_reg, a_data});
      if (b_valid && b_ready && b_reg != 4'd0) exp_b.push_back({b_reg, b_data});
`else
      if (a_valid && a_ready) exp_a.push_back({a_reg, a_data});
      if (b_valid && b_ready) exp_b.push_back({b_reg, b_data});
`endif
    end
  end

  // Every port write must be the oldest outstanding entry of one requester.
  always @(negedge clk) begin
    if (rst && WriteReg) begin
      checks++;
      if (exp_a.size() > 0 && exp_a[0] === {DstReg, DstData}) begin
        void'(exp_a.pop_front());
        obs.push_back(0);
      end else if (exp_b.size() > 0 && exp_b[0] === {DstReg, DstData}) begin
        void'(exp_b.pop_front());
        obs.push_back(1);
      end else begin
        errors++;
        $display("FAIL port_write got reg=%0d data=%h, not the head of either queue", DstReg, DstData);
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b0; flush = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    exp_a.delete(); exp_b.delete(); obs.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", WriteReg); end
    checks++; if (DstReg !== 4'd0) begin errors++; $display("FAIL reset_dstreg got %0d want 0", DstReg); end
    checks++; if (DstData !== 16'h0000) begin errors++; $display("FAIL reset_dstdata got %h want 0000", DstData); end
    checks++; if (pend_mask !== 16'h0000) begin errors++; $display("FAIL reset_pend got %h want 0000", pend_mask); end
    apply_reset();
    checks++; if ({a_ready, b_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", {a_ready, b_ready}); end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'hBEEF;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", WriteReg); end
    checks++; if (pend_mask !== 16'h0008) begin errors++; $display("FAIL single_pend1 got %h want 0008", pend_mask); end
    @(negedge clk);
    checks++; if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd3, 16'hBEEF}) begin
      errors++; $display("FAIL single_port got wr=%b reg=%0d data=%h want 1/3/beef", WriteReg, DstReg, DstData);
    end
    checks++; if (pend_mask !== 16'h0008) begin errors++; $display("FAIL single_pend2 got %h want 0008", pend_mask); end
    @(negedge clk);
    checks++; if ({WriteReg, pend_mask} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL single_after got wr=%b pend=%h want 0/0000", WriteReg, pend_mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int  ia = 0, ib = 0;
    logic ra, rb, exp_ra, exp_rb;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      a_valid = 1'b1; a_reg = 4'(ia); a_data = 16'hA000 + 16'(ia);
      b_valid = 1'b1; b_reg = 4'(ib + 8); b_data = 16'hB000 + 16'(ib);
      @(negedge clk);
      ra = a_ready; rb = b_ready;
      exp_ra = (c < 2) ? 1'b1 : (c % 2 == 0);
      exp_rb = (c < 2) ? 1'b1 : (c % 2 == 1);
      checks++; if ({ra, rb} !== {exp_ra, exp_rb}) begin
        errors++; $display("FAIL contention_ready cycle %0d got %b%b want %b%b", c, ra, rb, exp_ra, exp_rb);
      end
      @(posedge clk); #1;
      if (ra) ia++;
      if (rb) ib++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    checks++; if (obs.size() < 12) begin
      errors++; $display("FAIL contention_count got %0d writes want >=12", obs.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++; if (obs[k] != k % 2) begin
          errors++; $display("FAIL contention_order write %0d got side %0d want %0d", k, obs[k], k % 2);
        end
      end
    end
    checks++; if (exp_a.size() + exp_b.size() != 0) begin
      errors++; $display("FAIL contention_lost got %0d undrained want 0", exp_a.size() + exp_b.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      a_valid = 1'b1; a_reg = 4'(k + 1); a_data = 16'hE001 + 16'(k);
      @(negedge clk);
      if (k >= 2) begin
        checks++; if ({WriteReg, DstReg} !== {1'b1, 4'(k - 1)}) begin
          errors++; $display("FAIL b2b_port got wr=%b reg=%0d want 1/%0d", WriteReg, DstReg, k - 1);
        end
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    @(negedge clk);
    checks++; if ({WriteReg, DstReg, pend_mask} !== {1'b1, 4'd3, 16'h0018}) begin
      errors++; $display("FAIL b2b_third got wr=%b reg=%0d pend=%h want 1/3/0018", WriteReg, DstReg, pend_mask);
    end
    @(negedge clk);
    checks++; if ({WriteReg, DstReg} !== {1'b1, 4'd4}) begin
      errors++; $display("FAIL b2b_fourth got wr=%b reg=%0d want 1/4", WriteReg, DstReg);
    end
    @(negedge clk);
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", WriteReg); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    a_valid = 1'b1; a_reg = 4'd5; a_data = 16'hC001;
    b_valid = 1'b1; b_reg = 4'd5; b_data = 16'hC002;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0; flush = 1'b1;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL flush_ready got %b want 00", {a_ready, b_ready}); end
    checks++; if ({WriteReg, pend_mask} !== {1'b0, 16'h0020}) begin
      errors++; $display("FAIL flush_pre got wr=%b pend=%h want 0/0020", WriteReg, pend_mask);
    end
    @(posedge clk); #1 flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({WriteReg, pend_mask} !== {1'b0, 16'h0000}) begin
        errors++; $display("FAIL flush_post cycle %0d got wr=%b pend=%h want 0/0000", k, WriteReg, pend_mask);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      a_valid = 1'b1; a_reg = 4'd1; a_data = 16'hD0A0 + 16'(k);
      b_valid = 1'b1; b_reg = 4'd2; b_data = 16'hD0B0 + 16'(k);
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (WriteReg !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", WriteReg); end
    rst = 1'b0;
    exp_a.delete(); exp_b.delete();
    #1;
    checks++; if ({WriteReg, pend_mask} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL midrst_async got wr=%b pend=%h want 0/0000", WriteReg, pend_mask);
    end
    @(posedge clk); #1 rst = 1'b1;
    a_valid = 1'b1; a_reg = 4'd7; a_data = 16'hA777;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    checks++; if ({WriteReg, pend_mask} !== {1'b0, 16'h0080}) begin
      errors++; $display("FAIL midrst_stale got wr=%b pend=%h want 0/0080", WriteReg, pend_mask);
    end
    @(negedge clk);
    checks++; if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd7, 16'hA777}) begin
      errors++; $display("FAIL midrst_first got wr=%b reg=%0d data=%h want 1/7/a777", WriteReg, DstReg, DstData);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r0();
    a_valid = 1'b1; a_reg = 4'd0; a_data = 16'h1234;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b want 1", a_ready); end
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
`ifdef WB_R0_DROP_EN
    checks++; if (pend_mask !== 16'h0000) begin errors++; $display("FAIL r0_pend got %h want 0000", pend_mask); end
    @(negedge clk);
    checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL r0_write got %b want 0", WriteReg); end
`else
    checks++; if (pend_mask !== 16'h0001) begin errors++; $display("FAIL r0_pend got %h want 0001", pend_mask); end
    @(negedge clk);
    checks++; if ({WriteReg, DstReg, DstData} !== {1'b1, 4'd0, 16'h1234}) begin
      errors++; $display("FAIL r0_write got wr=%b reg=%0d data=%h want 1/0/1234", WriteReg, DstReg, DstData);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_r0();
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (exp_a.size() + exp_b.size() != 0) begin
      errors++; $display("FAIL final_drain got %0d undrained want 0", exp_a.size() + exp_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
